// File: rtl/clint_itrp_gen_if.sv
// Access/response bus between the MEM-stage uncached path and the CLINT.
// Also provides the shared bus-width and interrupt-bit-position macros.
`ifndef CLINT_ITRP_GEN_DEFS
`define CLINT_ITRP_GEN_DEFS
`define REG_BUS    63:0
`define ITRP_BUS   11:0
`define SOFT_ITRP  3
`define TIMER_ITRP 7
`define EXTER_ITRP 11
`endif

interface clint_itrp_gen_if;
   logic            acc_valid;
   logic            acc_ready;
   logic            acc_wen;
   logic [`REG_BUS] acc_addr;
   logic [`REG_BUS] acc_wdata;
   logic [7:0]      acc_wmask;
   logic            rsp_valid;
   logic [`REG_BUS] rsp_rdata;
   logic            rsp_err;

   modport master (
      output acc_valid, acc_wen, acc_addr, acc_wdata, acc_wmask,
      input  acc_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  acc_valid, acc_wen, acc_addr, acc_wdata, acc_wmask,
      output acc_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/clint_itrp_gen.sv
// Core-local interruptor: MSIP / MTIMECMP / MTIME registers, free-running
// mtime, and a gated per-cause interrupt vector for the exception handler.
// Optional feature macro: CLINT_TICK_DIV_EN (mtime prescaler by TICK_DIV,
// TICK_DIV must be a power of two >= 2).
`ifndef CLINT_ITRP_GEN_DEFS
`define CLINT_ITRP_GEN_DEFS
`define REG_BUS    63:0
`define ITRP_BUS   11:0
`define SOFT_ITRP  3
`define TIMER_ITRP 7
`define EXTER_ITRP 11
`endif

module clint_itrp_gen #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int          TICK_DIV  = 16
) (
   input  logic              clock,
   input  logic              reset,
   clint_itrp_gen_if.slave   acc,
   input  logic              ext_irq,
   input  logic [`REG_BUS]   mie_rd_data,
   input  logic              mstatus_mie,
   output logic [`ITRP_BUS]  itrp_info,
   output logic [`REG_BUS]   mip_rd_data
);

   localparam logic [63:0] ADDR_MSIP     = BASE_ADDR + 64'h0000;
   localparam logic [63:0] ADDR_MTIMECMP = BASE_ADDR + 64'h4000;
   localparam logic [63:0] ADDR_MTIME    = BASE_ADDR + 64'hBFF8;

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   state_t           state_reg, state_next;
   logic [63:0]      mtime_reg, mtime_next;
   logic [63:0]      mtimecmp_reg, mtimecmp_next;
   logic             msip_reg, msip_next;
   logic             mtip_reg;
   logic             ext_sync1_reg, ext_sync2_reg;
   logic [`ITRP_BUS] itrp_reg, itrp_next;
   logic [63:0]      rdata_reg, rdata_next;
   logic             err_reg, err_next;

   logic [63:0]      wmask_bits;
   logic             accept;
   logic             sel_msip, sel_mtimecmp, sel_mtime;
   logic             wr_mtime;
   logic             tick;
   logic             unused_bits;

   // Expand the byte enables to a per-bit mask
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_wmask
         assign wmask_bits[gi*8 +: 8] = {8{acc.acc_wmask[gi]}};
      end
   endgenerate

   assign sel_msip     = (acc.acc_addr == ADDR_MSIP);
   assign sel_mtimecmp = (acc.acc_addr == ADDR_MTIMECMP);
   assign sel_mtime    = (acc.acc_addr == ADDR_MTIME);
   assign wr_mtime     = accept & acc.acc_wen & sel_mtime;

`ifdef CLINT_TICK_DIV_EN
   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRESC_W-1:0] presc_reg, presc_next;

   // Prescaler: mtime ticks when it wraps to zero; an MTIME write restarts it
   always_comb begin
      presc_next = presc_reg + 1'b1;
      tick       = (presc_next == '0);
      if (wr_mtime) begin
         presc_next = '0;
      end
   end

   // Prescaler register
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_next;
      end
   end

   assign unused_bits = ^{mie_rd_data[63:12], mie_rd_data[10:8], mie_rd_data[6:4], mie_rd_data[2:0]};
`else
   localparam logic [31:0] TICK_DIV_BITS = 32'(TICK_DIV);

   assign tick        = 1'b1;
   assign unused_bits = ^{mie_rd_data[63:12], mie_rd_data[10:8], mie_rd_data[6:4], mie_rd_data[2:0],
                          TICK_DIV_BITS[0]};
`endif

   // Handshake FSM: accept in IDLE, one-cycle response strobe in RESP
   always_comb begin
      state_next    = state_reg;
      accept        = 1'b0;
      acc.acc_ready = 1'b0;
      acc.rsp_valid = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            acc.acc_ready = 1'b1;
            if (acc.acc_valid) begin
               accept     = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            acc.rsp_valid = 1'b1;
            state_next    = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Register file: byte-masked writes, read sampling, mtime advance
   always_comb begin
      msip_next     = msip_reg;
      mtimecmp_next = mtimecmp_reg;
      mtime_next    = tick ? (mtime_reg + 64'd1) : mtime_reg;
      rdata_next    = rdata_reg;
      err_next      = err_reg;
      if (accept) begin
         rdata_next = '0;
         err_next   = ~(sel_msip | sel_mtimecmp | sel_mtime);
         if (acc.acc_wen) begin
            if (sel_msip && acc.acc_wmask[0]) begin
               msip_next = acc.acc_wdata[0];
            end
            if (sel_mtimecmp) begin
               mtimecmp_next = (mtimecmp_reg & ~wmask_bits) | (acc.acc_wdata & wmask_bits);
            end
            // A software write overrides the increment for this cycle
            if (sel_mtime) begin
               mtime_next = (mtime_reg & ~wmask_bits) | (acc.acc_wdata & wmask_bits);
            end
         end else begin
            if (sel_msip) begin
               rdata_next = {63'b0, msip_reg};
            end
            if (sel_mtimecmp) begin
               rdata_next = mtimecmp_reg;
            end
            if (sel_mtime) begin
               rdata_next = mtime_reg;
            end
         end
      end
   end

   // Gate pending causes so every asserted bit is takeable
   always_comb begin
      itrp_next              = '0;
      itrp_next[`SOFT_ITRP]  = msip_reg      & mie_rd_data[3]  & mstatus_mie;
      itrp_next[`TIMER_ITRP] = mtip_reg      & mie_rd_data[7]  & mstatus_mie;
      itrp_next[`EXTER_ITRP] = ext_sync2_reg & mie_rd_data[11] & mstatus_mie;
   end

   // Ungated pending view for CSR reads
   always_comb begin
      mip_rd_data     = '0;
      mip_rd_data[3]  = msip_reg;
      mip_rd_data[7]  = mtip_reg;
      mip_rd_data[11] = ext_sync2_reg;
   end

   // State registers; reset also drops an in-flight response
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         mtime_reg     <= '0;
         mtimecmp_reg  <= '1;
         msip_reg      <= 1'b0;
         mtip_reg      <= 1'b0;
         ext_sync1_reg <= 1'b0;
         ext_sync2_reg <= 1'b0;
         itrp_reg      <= '0;
         rdata_reg     <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mtime_reg     <= mtime_next;
         mtimecmp_reg  <= mtimecmp_next;
         msip_reg      <= msip_next;
         mtip_reg      <= (mtime_reg >= mtimecmp_reg);
         ext_sync1_reg <= ext_irq;
         ext_sync2_reg <= ext_sync1_reg;
         itrp_reg      <= itrp_next;
         rdata_reg     <= rdata_next;
         err_reg       <= err_next;
      end
   end

   assign acc.rsp_rdata = rdata_reg;
   assign acc.rsp_err   = err_reg;
   assign itrp_info     = itrp_reg;

endmodule

// File: tb/tb_clint_itrp_gen.sv
// Directed self-checking bench for clint_itrp_gen.
module tb_clint_itrp_gen;

   localparam logic [63:0] BASE       = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_MSIP     = BASE + 64'h0000;
   localparam logic [63:0] A_MTIMECMP = BASE + 64'h4000;
   localparam logic [63:0] A_MTIME    = BASE + 64'hBFF8;
   localparam logic [63:0] A_HOLE     = BASE + 64'h0008;
   localparam logic [63:0] ONES       = 64'hFFFF_FFFF_FFFF_FFFF;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             ext_irq = 1'b0;
   logic [`REG_BUS]  mie_rd_data = '0;
   logic             mstatus_mie = 1'b0;
   logic [`ITRP_BUS] itrp_info;
   logic [`REG_BUS]  mip_rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   clint_itrp_gen_if bus();

   clint_itrp_gen #(.BASE_ADDR(BASE), .TICK_DIV(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .acc         (bus),
      .ext_irq     (ext_irq),
      .mie_rd_data (mie_rd_data),
      .mstatus_mie (mstatus_mie),
      .itrp_info   (itrp_info),
      .mip_rd_data (mip_rd_data)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One bus transaction; returns the response data and error flag
   task automatic bus_acc(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
      int waited = 0;
      while (!bus.acc_ready && waited < 20) begin
         step();
         waited++;
      end
      check_val("acc_ready", bus.acc_ready, 1);
      bus.acc_valid = 1'b1;
      bus.acc_wen   = wen;
      bus.acc_addr  = addr;
      bus.acc_wdata = wdata;
      bus.acc_wmask = wmask;
      step();
      bus.acc_valid = 1'b0;
      check_val("rsp_valid_hi", bus.rsp_valid, 1);
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      step();
      check_val("rsp_valid_lo", bus.rsp_valid, 0);
      $display("xact %s addr=%h wdata=%h mask=%h -> rdata=%h err=%0b",
               wen ? "WR" : "RD", addr, wdata, wmask, rdata, err);
   endtask

   logic [63:0] rd;
   logic        er;
   int          rise_mip, rise_itrp;

   initial begin
      bus.acc_valid = 1'b0;
      bus.acc_wen   = 1'b0;
      bus.acc_addr  = '0;
      bus.acc_wdata = '0;
      bus.acc_wmask = '0;
      repeat (3) step();
      reset = 1'b0;

      // Reset state
      check_val("rst_acc_ready", bus.acc_ready, 1);
      check_val("rst_rsp_valid", bus.rsp_valid, 0);
      check_val("rst_rsp_rdata", bus.rsp_rdata, 0);
      check_val("rst_rsp_err", bus.rsp_err, 0);
      check_val("rst_itrp", 64'(itrp_info), 0);
      check_val("rst_mip", mip_rd_data, 0);

      // MTIMECMP reset value
      bus_acc(0, A_MTIMECMP, 0, 8'h00, rd, er);
      check_val("mtimecmp_rst", rd, ONES);
      check_val("mtimecmp_err", er, 0);

      // Software interrupt and its gating
      mie_rd_data = 64'h8;
      mstatus_mie = 1'b1;
      bus_acc(1, A_MSIP, 64'h1, 8'h01, rd, er);
      check_val("soft_itrp_on", itrp_info[`SOFT_ITRP], 1);
      check_val("soft_mip_on", mip_rd_data[3], 1);
      mstatus_mie = 1'b0;
      check_val("soft_itrp_hold", itrp_info[`SOFT_ITRP], 1);
      step();
      check_val("soft_itrp_gated", itrp_info[`SOFT_ITRP], 0);
      check_val("soft_mip_ungated", mip_rd_data[3], 1);
      bus_acc(1, A_MSIP, ONES, 8'hFF, rd, er);
      bus_acc(0, A_MSIP, 0, 8'h00, rd, er);
      check_val("msip_bit0_only", rd, 64'h1);
      bus_acc(1, A_MSIP, 64'h0, 8'hFF, rd, er);
      check_val("msip_cleared_mip", mip_rd_data[3], 0);
      bus_acc(1, A_MSIP, 64'h1, 8'h00, rd, er);
      bus_acc(0, A_MSIP, 0, 8'h00, rd, er);
      check_val("msip_masked_drop", rd, 64'h0);

`ifndef CLINT_TICK_DIV_EN
      // Timer interrupt: mtime 100 -> compare 105
      mie_rd_data = 64'h80;
      mstatus_mie = 1'b1;
      bus_acc(1, A_MTIME, 64'd100, 8'hFF, rd, er);
      bus_acc(1, A_MTIMECMP, 64'd105, 8'hFF, rd, er);
      check_val("timer_mip_early", mip_rd_data[7], 0);
      rise_mip  = -1;
      rise_itrp = -1;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (mip_rd_data[7] && rise_mip < 0) rise_mip = n;
         if (itrp_info[`TIMER_ITRP] && rise_itrp < 0) rise_itrp = n;
      end
      check_val("timer_mip_rise_cyc", 64'(rise_mip), 64'd3);
      check_val("timer_itrp_rise_cyc", 64'(rise_itrp), 64'd4);
      bus_acc(1, A_MTIMECMP, ONES, 8'hFF, rd, er);
      check_val("timer_mip_clear", mip_rd_data[7], 0);
      step();
      check_val("timer_itrp_clear", itrp_info[`TIMER_ITRP], 0);

      // mtime wrap-around
      bus_acc(1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
      step();
      bus_acc(0, A_MTIME, 0, 8'h00, rd, er);
      check_val("mtime_wrap", rd, 64'h0);
`else
      // Prescaled mtime: one increment per 16 cycles
      bus_acc(1, A_MTIME, 64'h0, 8'hFF, rd, er);
      bus_acc(0, A_MTIME, 0, 8'h00, rd, er);
      check_val("div_mtime_t0", rd, 64'h0);
      repeat (14) step();
      bus_acc(0, A_MTIME, 0, 8'h00, rd, er);
      check_val("div_mtime_t16", rd, 64'h1);
`endif

      // Byte-masked MTIMECMP write
      bus_acc(1, A_MTIMECMP, 64'h0000_0000_0000_1234, 8'h03, rd, er);
      bus_acc(0, A_MTIMECMP, 0, 8'h00, rd, er);
      check_val("mtimecmp_masked", rd, 64'hFFFF_FFFF_FFFF_1234);

      // Unmapped address
      bus_acc(0, A_HOLE, 0, 8'h00, rd, er);
      check_val("hole_rd_data", rd, 64'h0);
      check_val("hole_rd_err", er, 1);
      bus_acc(1, A_HOLE, ONES, 8'hFF, rd, er);
      check_val("hole_wr_err", er, 1);
      bus_acc(0, A_MSIP, 0, 8'h00, rd, er);
      check_val("hole_msip_kept", rd, 64'h0);
      check_val("msip_rd_err", er, 0);
      bus_acc(0, A_MTIMECMP, 0, 8'h00, rd, er);
      check_val("hole_mtimecmp_kept", rd, 64'hFFFF_FFFF_FFFF_1234);
      bus_acc(0, A_MTIME, 0, 8'h00, rd, er);
      check_val("hole_mtime_kept", 64'(rd < 64'd1000), 64'h1);

      // External interrupt through the synchronizer
      mie_rd_data = 64'h800;
      mstatus_mie = 1'b1;
      ext_irq = 1'b1;
      step();
      check_val("ext_mip_1cyc", mip_rd_data[11], 0);
      step();
      check_val("ext_mip_2cyc", mip_rd_data[11], 1);
      step();
      check_val("ext_itrp_vec", 64'(itrp_info), 64'h800);
      step();
      step();
      ext_irq = 1'b0;
      step();
      check_val("ext_mip_hold", mip_rd_data[11], 1);
      step();
      check_val("ext_mip_drop", mip_rd_data[11], 0);

      // Reset while a response is pending
      bus.acc_valid = 1'b1;
      bus.acc_wen   = 1'b1;
      bus.acc_addr  = A_MTIMECMP;
      bus.acc_wdata = 64'd5;
      bus.acc_wmask = 8'hFF;
      step();
      bus.acc_valid = 1'b0;
      check_val("rresp_valid_pre", bus.rsp_valid, 1);
      reset = 1'b1;
      step();
      check_val("rresp_valid_drop", bus.rsp_valid, 0);
      check_val("rresp_ready", bus.acc_ready, 1);
      check_val("rresp_itrp", 64'(itrp_info), 0);
      reset = 1'b0;
      bus_acc(0, A_MTIMECMP, 0, 8'h00, rd, er);
      check_val("rresp_mtimecmp", rd, ONES);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
